// File: rtl/shift_deser_pkg.sv
// Shared types for the serial-to-parallel receiver: bit order, FSM state and
// the bit counter width helper.
package shift_deser_pkg;

    typedef enum logic {
        DIR_MSB_FIRST = 1'b0,
        DIR_LSB_FIRST = 1'b1
    } dir_e;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/deser_hold_buf.sv
// One-entry valid/ready holding buffer with parity sideband; a write is taken
// when empty or draining this cycle, otherwise dropped and overrun latches.
module deser_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             wr_par_i,
    input  logic             rd_rdy_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             rd_vld_o,
    output logic             rd_par_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] dat_q;
    logic             vld_q;
    logic             par_q;
    logic             ovr_q;
    logic             pop;
    logic             load;

    assign pop  = vld_q && rd_rdy_i;
    assign load = wr_vld_i && (!vld_q || rd_rdy_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            dat_q <= '0;
            vld_q <= 1'b0;
            par_q <= 1'b0;
            ovr_q <= 1'b0;
        end else if (load) begin
            dat_q <= wr_dat_i;
            par_q <= wr_par_i;
            vld_q <= 1'b1;
        end else begin
            if (pop) begin
                vld_q <= 1'b0;
            end
            // Reaching here with a write means the buffer is full and stalled.
            if (wr_vld_i) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign rd_dat_o  = dat_q;
    assign rd_vld_o  = vld_q;
    assign rd_par_o  = par_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: word on q one cycle after its last bit, held in a
// one-entry buffer under backpressure. SHIFT_DESER_PARITY_EN adds a trailing even-parity bit.
module shift_deserializer
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sin_valid,
    input  logic                        sin,
    input  logic                        dir,
    input  logic                        q_ready,
    output logic [WIDTH-1:0]            q,
    output logic                        q_valid,
    output logic [cnt_width(WIDTH)-1:0] bit_cnt,
    output logic                        overrun,
    output logic                        parity_err
);

    localparam int CNT_W = cnt_width(WIDTH);
`ifdef SHIFT_DESER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

    state_e           state_q;
    dir_e             dir_q;
    dir_e             cur_dir;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CNT_W-1:0] cnt_q;
    logic             shift_en;
    logic             commit_vld;
    logic [WIDTH-1:0] commit_dat;
    logic             commit_par;

    // The first bit of a word uses the live dir; later bits use the latched one.
    assign cur_dir = (state_q == IDLE) ? dir_e'(dir) : dir_q;

    always_comb begin
        sr_d = sr_q;
        if (cur_dir == DIR_MSB_FIRST) begin
            sr_d = {sr_q[WIDTH-2:0], sin};
        end else begin
            sr_d = {sin, sr_q[WIDTH-1:1]};
        end
    end

    assign commit_vld = sin_valid && (cnt_q == LAST_IDX);

`ifdef SHIFT_DESER_PARITY_EN
    // The parity bit is checked but never shifted into the data word.
    assign shift_en   = (cnt_q != LAST_IDX);
    assign commit_dat = sr_q;
    assign commit_par = ^{sr_q, sin};
`else
    assign shift_en   = 1'b1;
    assign commit_dat = sr_d;
    assign commit_par = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_MSB_FIRST;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else if (sin_valid) begin
            if (shift_en) begin
                sr_q <= sr_d;
            end
            case (state_q)
                IDLE: begin
                    dir_q   <= dir_e'(dir);
                    state_q <= COLLECT;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                COLLECT: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bit_cnt = cnt_q;

    deser_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_vld_i (commit_vld),
        .wr_dat_i (commit_dat),
        .wr_par_i (commit_par),
        .rd_rdy_i (q_ready),
        .rd_dat_o (q),
        .rd_vld_o (q_valid),
        .rd_par_o (parity_err),
        .overrun_o(overrun)
    );

endmodule
